// File: rtl/tcn_fifo_pkg.sv
// rtl/tcn_fifo_pkg.sv - shared ring-region types and address map function
// Purpose: per-channel ring state record and the logical->physical ring map,
//          shared by the RTL map sub-module and the controller model.
// Contents: RING_ADDR_W, ring_addr_t, ring_cfg_t, ring_map_t, ring_map().
package tcn_fifo_pkg;

  localparam int RING_ADDR_W = 12;

  typedef logic [RING_ADDR_W-1:0] ring_addr_t;

  // size is block_size*total_blocks precomputed at config time; size==0 means unmapped.
  typedef struct packed {
    ring_addr_t base;
    ring_addr_t block_size;
    ring_addr_t total_blocks;
    ring_addr_t size;
    ring_addr_t head;
    ring_addr_t fill;
  } ring_cfg_t;

  typedef struct packed {
    ring_addr_t addr;
    logic       oob;
  } ring_map_t;

  // Rotate a logical address by the head pointer and wrap inside the region.
  // head < size and addr < size, so a single conditional subtract suffices.
  function automatic ring_map_t ring_map(input ring_cfg_t cfg, input ring_addr_t addr);
    logic [RING_ADDR_W:0] off;
    ring_map_t            res;
    off      = {1'b0, addr} + {1'b0, cfg.head};
    res.addr = addr;
    res.oob  = 1'b0;
    if (cfg.size != '0) begin
      if (addr >= cfg.size) begin
        // Out-of-range accesses are pinned to the region base so they never escape it.
        res.addr = cfg.base;
        res.oob  = 1'b1;
      end else begin
        if (off >= {1'b0, cfg.size}) begin
          off = off - {1'b0, cfg.size};
        end
        res.addr = cfg.base + off[RING_ADDR_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tcn_ring_map.sv
// rtl/tcn_ring_map.sv - combinational ring address map for one access port
// Purpose: bypass or ring-map a logical address using one channel's ring state.
// Ports:
//   active   in   1        0: pass addr_in through, 1: apply ring mapping
//   cfg      in   struct   ring state of the selected channel
//   addr_in  in   ADDR_W   logical address
//   addr_out out  ADDR_W   physical address
//   oob      out  1        logical address outside the ring
module tcn_ring_map
  import tcn_fifo_pkg::*;
#(
  parameter int ADDR_W = RING_ADDR_W
) (
  input  logic              active,
  input  ring_cfg_t         cfg,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              oob
);

  ring_map_t mapped;

  always_comb begin
    mapped = ring_map(cfg, addr_in);
    if (!active) begin
      addr_out = addr_in;
      oob      = 1'b0;
    end else begin
      addr_out = mapped.addr;
      oob      = mapped.oob;
    end
  end

endmodule

// File: rtl/tcn_ring_addr_mapper.sv
// rtl/tcn_ring_addr_mapper.sv - multi-channel circular-buffer address translator
// Purpose: per-channel ring regions for TCN incremental execution; rotates read and
//          write addresses by the channel head pointer, registered 1-cycle outputs.
// Ports:
//   clk, reset (async active-low)
//   active                         0: bypass, 1: ring mapping
//   cfg_we/cfg_ch/cfg_base/cfg_block_size/cfg_total_blocks  channel config write
//   cfg_err                        pulse: previous config write rejected
//   adv/adv_ch                     advance one channel's head by one block
//   rd_req/rd_ch/rd_addr_in -> rd_valid/rd_addr_out/rd_oob   read port
//   wr_req/wr_ch/wr_addr_in -> wr_valid/wr_addr_out/wr_oob   write port
//   full                           per channel: ring holds total_blocks vectors
module tcn_ring_addr_mapper
  import tcn_fifo_pkg::*;
#(
  parameter int ADDR_W = RING_ADDR_W,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_block_size,
  input  logic [ADDR_W-1:0] cfg_total_blocks,
  output logic              cfg_err,
  input  logic              adv,
  input  logic [CH_W-1:0]   adv_ch,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic              rd_oob,
  input  logic              wr_req,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr_in,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic              wr_oob,
  output logic [NUM_CH-1:0] full
);

  // ---------------------------------------------------------------------------
  // Config validation: full-width product, and the region must end at or below 2^ADDR_W.
  // ---------------------------------------------------------------------------
  logic [2*ADDR_W-1:0] cfg_prod;
  logic [ADDR_W:0]     cfg_end;
  logic                cfg_bad;

  always_comb begin
    cfg_prod = {{ADDR_W{1'b0}}, cfg_block_size} * {{ADDR_W{1'b0}}, cfg_total_blocks};
    cfg_end  = {1'b0, cfg_base} + {1'b0, cfg_prod[ADDR_W-1:0]};
    cfg_bad  = (|cfg_prod[2*ADDR_W-1:ADDR_W]) || (cfg_end > {1'b1, {ADDR_W{1'b0}}});
  end

  // ---------------------------------------------------------------------------
  // Per-channel ring state
  // ---------------------------------------------------------------------------
  ring_cfg_t ring_all [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ring_cfg_t       ring_q;
    logic            cfg_hit;
    logic            adv_hit;
    logic [ADDR_W:0] head_sum;

    always_comb begin
      // A rejected config leaves the channel alone, so it does not block an advance.
      cfg_hit  = cfg_we && !cfg_bad && (cfg_ch == CH_W'(i));
      adv_hit  = adv && (adv_ch == CH_W'(i)) && (ring_q.size != '0);
      head_sum = {1'b0, ring_q.head} + {1'b0, ring_q.block_size};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ring_q <= '0;
      end else if (cfg_hit) begin
        ring_q.base         <= cfg_base;
        ring_q.block_size   <= cfg_block_size;
        ring_q.total_blocks <= cfg_total_blocks;
        ring_q.size         <= cfg_prod[ADDR_W-1:0];
        ring_q.head         <= '0;
        ring_q.fill         <= '0;
      end else if (adv_hit) begin
        ring_q.head <= (head_sum >= {1'b0, ring_q.size}) ? '0 : head_sum[ADDR_W-1:0];
        if (ring_q.fill != ring_q.total_blocks) begin
          ring_q.fill <= ring_q.fill + 1'b1;
        end
      end
    end

    assign ring_all[i] = ring_q;
    // Unmapped channels never report full even though fill==total_blocks==0.
    assign full[i]     = (ring_q.size != '0) && (ring_q.fill == ring_q.total_blocks);
  end

  // ---------------------------------------------------------------------------
  // Port channel select and map (uses current state: pre-advance, pre-config)
  // ---------------------------------------------------------------------------
  ring_cfg_t         rd_cfg;
  ring_cfg_t         wr_cfg;
  logic [ADDR_W-1:0] rd_map_addr;
  logic [ADDR_W-1:0] wr_map_addr;
  logic              rd_map_oob;
  logic              wr_map_oob;

  always_comb begin
    rd_cfg = '0;
    wr_cfg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_cfg = ring_all[i];
      if (wr_ch == CH_W'(i)) wr_cfg = ring_all[i];
    end
  end

  tcn_ring_map #(.ADDR_W(ADDR_W)) u_rd_map (
    .active   (active),
    .cfg      (rd_cfg),
    .addr_in  (rd_addr_in),
    .addr_out (rd_map_addr),
    .oob      (rd_map_oob)
  );

  tcn_ring_map #(.ADDR_W(ADDR_W)) u_wr_map (
    .active   (active),
    .cfg      (wr_cfg),
    .addr_in  (wr_addr_in),
    .addr_out (wr_map_addr),
    .oob      (wr_map_oob)
  );

  // ---------------------------------------------------------------------------
  // Output registers: address/oob hold when there is no request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_addr_out <= '0;
      rd_oob      <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr_out <= '0;
      wr_oob      <= 1'b0;
    end else begin
      cfg_err  <= cfg_we && cfg_bad;
      rd_valid <= rd_req;
      wr_valid <= wr_req;
      if (rd_req) begin
        rd_addr_out <= rd_map_addr;
        rd_oob      <= rd_map_oob;
      end
      if (wr_req) begin
        wr_addr_out <= wr_map_addr;
        wr_oob      <= wr_map_oob;
      end
    end
  end

endmodule

// File: tb/tb_tcn_ring_addr_mapper.sv
// tb/tb_tcn_ring_addr_mapper.sv - directed self-checking bench for tcn_ring_addr_mapper
module tb_tcn_ring_addr_mapper;

  localparam int ADDR_W = 12;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              active;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_block_size;
  logic [ADDR_W-1:0] cfg_total_blocks;
  logic              cfg_err;
  logic              adv;
  logic [CH_W-1:0]   adv_ch;
  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic [ADDR_W-1:0] rd_addr_in;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_out;
  logic              rd_oob;
  logic              wr_req;
  logic [CH_W-1:0]   wr_ch;
  logic [ADDR_W-1:0] wr_addr_in;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr_out;
  logic              wr_oob;
  logic [NUM_CH-1:0] full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcn_ring_addr_mapper #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk              (clk),
    .reset            (reset),
    .active           (active),
    .cfg_we           (cfg_we),
    .cfg_ch           (cfg_ch),
    .cfg_base         (cfg_base),
    .cfg_block_size   (cfg_block_size),
    .cfg_total_blocks (cfg_total_blocks),
    .cfg_err          (cfg_err),
    .adv              (adv),
    .adv_ch           (adv_ch),
    .rd_req           (rd_req),
    .rd_ch            (rd_ch),
    .rd_addr_in       (rd_addr_in),
    .rd_valid         (rd_valid),
    .rd_addr_out      (rd_addr_out),
    .rd_oob           (rd_oob),
    .wr_req           (wr_req),
    .wr_ch            (wr_ch),
    .wr_addr_in       (wr_addr_in),
    .wr_valid         (wr_valid),
    .wr_addr_out      (wr_addr_out),
    .wr_oob           (wr_oob),
    .full             (full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we = 1'b0; adv = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] b,
                        input logic [ADDR_W-1:0] bs, input logic [ADDR_W-1:0] tb);
    cfg_we = 1'b1; cfg_ch = ch; cfg_base = b; cfg_block_size = bs; cfg_total_blocks = tb;
  endtask

  task automatic do_rd(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] a);
    rd_req = 1'b1; rd_ch = ch; rd_addr_in = a;
  endtask

  task automatic do_wr(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] a);
    wr_req = 1'b1; wr_ch = ch; wr_addr_in = a;
  endtask

  task automatic do_adv(input logic [CH_W-1:0] ch);
    adv = 1'b1; adv_ch = ch;
  endtask

  initial begin
    reset = 1'b0; active = 1'b0; idle();
    cfg_ch = '0; cfg_base = '0; cfg_block_size = '0; cfg_total_blocks = '0;
    adv_ch = '0; rd_ch = '0; wr_ch = '0; rd_addr_in = '0; wr_addr_in = '0;
    do_rd(2'd0, 12'h3AA);
    tick(); tick();
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_addr",  32'(rd_addr_out), 32'h0);
    check("rst_full",     32'(full), 32'h0);
    check("rst_cfg_err",  32'(cfg_err), 32'h0);
    idle();
    reset = 1'b1;
    tick();

    // Bypass
    do_rd(2'd0, 12'h123);
    tick();
    check("byp_valid", 32'(rd_valid), 32'h1);
    check("byp_addr",  32'(rd_addr_out), 32'h123);
    check("byp_oob",   32'(rd_oob), 32'h0);
    idle();
    tick();
    check("byp_valid_drop", 32'(rd_valid), 32'h0);
    check("byp_addr_hold",  32'(rd_addr_out), 32'h123);

    // Configure ch1: base 0x100, 4 words x 3 blocks = size 12
    active = 1'b1;
    do_cfg(2'd1, 12'h100, 12'd4, 12'd3);
    tick();
    check("cfg1_err", 32'(cfg_err), 32'h0);
    check("cfg1_full", 32'(full), 32'h0);
    idle();
    // Unmapped channel passes through even when active
    do_rd(2'd0, 12'h055);
    tick();
    check("unmapped_addr", 32'(rd_addr_out), 32'h055);
    idle();

    // Two advances -> head 8
    do_adv(2'd1); tick();
    do_adv(2'd1); tick();
    idle();
    check("adv2_full", 32'(full), 32'h0);
    do_rd(2'd1, 12'd5);
    do_wr(2'd1, 12'd3);
    tick();
    check("wrap_rd", 32'(rd_addr_out), 32'h101);
    check("wrap_wr", 32'(wr_addr_out), 32'h10B);
    check("wrap_wr_valid", 32'(wr_valid), 32'h1);
    idle();

    // Third advance wraps head to 0, ring becomes full
    do_adv(2'd1); tick();
    idle();
    check("adv3_full", 32'(full), 32'h2);
    do_rd(2'd1, 12'd0);
    tick();
    check("adv3_rd", 32'(rd_addr_out), 32'h100);
    idle();

    // Access and advance same cycle: access sees pre-advance head 0; fill saturates
    do_rd(2'd1, 12'd0);
    do_adv(2'd1);
    tick();
    check("coll_rd", 32'(rd_addr_out), 32'h100);
    idle();
    do_rd(2'd1, 12'd0);
    tick();
    check("coll_next_rd", 32'(rd_addr_out), 32'h104);
    check("sat_full", 32'(full), 32'h2);
    idle();

    // OOB on read, in-range wrap on write (head 4: 11+4-12 = 3)
    do_rd(2'd1, 12'd12);
    do_wr(2'd1, 12'd11);
    tick();
    check("oob_flag", 32'(rd_oob), 32'h1);
    check("oob_addr", 32'(rd_addr_out), 32'h100);
    check("oob_wr_flag", 32'(wr_oob), 32'h0);
    check("oob_wr_addr", 32'(wr_addr_out), 32'h103);
    idle();

    // Bad config (product 0x2000 overflows): rejected, one-cycle pulse, ch1 unchanged
    do_cfg(2'd1, 12'hF00, 12'h100, 12'h020);
    tick();
    check("bad_cfg_err", 32'(cfg_err), 32'h1);
    idle();
    do_rd(2'd1, 12'd0);
    tick();
    check("bad_cfg_pulse", 32'(cfg_err), 32'h0);
    check("bad_cfg_keep", 32'(rd_addr_out), 32'h104);
    check("bad_cfg_full", 32'(full), 32'h2);
    idle();

    // Region ending exactly at 2^ADDR_W accepted; one word further rejected
    do_cfg(2'd2, 12'hF00, 12'h010, 12'h010);
    tick();
    check("edge_cfg_ok", 32'(cfg_err), 32'h0);
    do_cfg(2'd3, 12'hF01, 12'h010, 12'h010);
    tick();
    check("edge_cfg_bad", 32'(cfg_err), 32'h1);
    idle();
    do_rd(2'd2, 12'h0FF);
    do_wr(2'd3, 12'h0FF);
    tick();
    check("edge_rd_top", 32'(rd_addr_out), 32'hFFF);
    check("edge_wr_unmapped", 32'(wr_addr_out), 32'h0FF);
    idle();

    // Config + advance + access same channel: access old config, config wins over advance
    do_cfg(2'd1, 12'h200, 12'd2, 12'd2);
    do_adv(2'd1);
    do_rd(2'd1, 12'd1);
    tick();
    check("cfgcoll_rd_old", 32'(rd_addr_out), 32'h105);
    idle();
    do_rd(2'd1, 12'd1);
    tick();
    check("cfgcoll_rd_new", 32'(rd_addr_out), 32'h201);
    check("cfgcoll_full", 32'(full), 32'h0);
    idle();

    // Reset mid-stream
    do_adv(2'd1);
    do_rd(2'd2, 12'd1);
    do_wr(2'd1, 12'd1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
    check("mid_rst_rd_addr",  32'(rd_addr_out), 32'h0);
    check("mid_rst_wr_addr",  32'(wr_addr_out), 32'h0);
    check("mid_rst_full",     32'(full), 32'h0);
    idle();
    tick();
    reset = 1'b1;
    do_rd(2'd1, 12'd3);
    tick();
    check("post_rst_unmapped", 32'(rd_addr_out), 32'h003);
    idle();
    do_cfg(2'd1, 12'h100, 12'd4, 12'd3);
    tick();
    idle();
    do_rd(2'd1, 12'd3);
    tick();
    check("post_rst_head0", 32'(rd_addr_out), 32'h103);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
